counter_monitor: RTL and testbench
==================================

Name: counter_monitor

Overview:
- Hardware checker that sits on the far side of the up/down/load counter interface and watches the counter's control inputs and its cnt output every cycle.
- It predicts the next cnt value from the previous cycle's controls and observed count, then compares the prediction against the actual value.
- It flags mismatches, counts errors, and captures the first failing pair for debug.
- Intended for in-system self-check and for reuse as a scoreboard in counter benches.

Parameters:
WIDTH, 4, counter width in bits (cnt, load, captured values)
ERRW, 8, width of error counter (saturating)

Ports:
clk  in  1  rising-edge clock, same clock as the monitored counter
reset  in  1  asynchronous, active-low reset
check_en  in  1  1 = monitoring active; 0 = monitor idle, no comparisons
err_clr  in  1  synchronous clear of err_flag, err_count, first_* captures
en_load  in  1  monitored counter load enable
load  in  WIDTH  monitored counter load value
up_ndown  in  1  monitored counter direction (1 = up, 0 = down)
cnt  in  WIDTH  monitored counter output
mismatch  out  1  one-cycle pulse: cnt differed from prediction this cycle
err_flag  out  1  sticky: at least one mismatch since reset/clear
err_count  out  ERRW  number of mismatches, saturates at all-ones
exp_cnt  out  WIDTH  current prediction (valid when in CHECK)
first_exp  out  WIDTH  prediction at first mismatch
first_got  out  WIDTH  observed cnt at first mismatch

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; all outputs and internal registers = 0.
- Counter model, per rising edge: en_load = 1 -> next = load; else up_ndown = 1 -> next = cnt + 1; else next = cnt - 1.
- All arithmetic is modulo 2^WIDTH: all-ones + 1 = 0; 0 - 1 = all-ones.
- en_load has priority over up_ndown.
- States: IDLE, SYNC, CHECK.
- IDLE: no prediction, no comparison. check_en = 1 -> SYNC.
- SYNC, one cycle:
  - Registers cnt, en_load, load, up_ndown; computes exp_cnt from them.
  - Goes to CHECK with no comparison, so the first observed value becomes the baseline.
- CHECK, every cycle:
  - Compare cnt against exp_cnt registered on the previous edge.
  - On inequality: mismatch = 1 for exactly that cycle, registered output.
  - Then re-predict from the currently observed cnt, not from exp_cnt, so a single glitch yields one error rather than a cascade.
- Latency:
  - The prediction from controls sampled at edge k is compared against cnt sampled at edge k+1.
  - mismatch asserts at edge k+1, i.e. it is visible after edge k+1.
- check_en = 0 in SYNC or CHECK -> IDLE at the next edge; no comparison on that edge; mismatch = 0.
- Re-asserting check_en always passes through SYNC, so there is never a compare against stale data.
- Error bookkeeping on a mismatch:
  - err_flag <= 1.
  - err_count <= err_count + 1, holding at 2^ERRW - 1 once reached.
  - first_exp / first_got are loaded only when err_flag was 0 before this edge.
- err_clr = 1:
  - Clears err_flag, err_count, first_exp, first_got at the edge.
  - If a mismatch occurs on the same edge, the clear wins for err_count/err_flag/first_*, but the mismatch pulse still asserts.
- err_clr does not change state or exp_cnt.
- reset asserted mid-operation: immediate return to IDLE, all outputs 0; a re-sync is required.
- exp_cnt holds its last value in IDLE. exp_cnt is don't-care outside CHECK but must be deterministic.

Test Plan:
1. Reset low, then high, check_en = 1, en_load = 1, load = 0 for 1 cycle, then en_load = 0, up_ndown = 1 for 20 cycles, cnt driven by a correct counter -> mismatch never asserts; err_count = 0; cnt wraps 15 -> 0 with no error (WIDTH = 4).
2. Correct counter counting down from load = 2 -> 1, 0, 15, 14 accepted; err_flag stays 0.
3. In CHECK, force cnt = 9 when 5 is expected for one cycle, then resume correct behaviour -> exactly one mismatch pulse; err_count = 1; first_exp = 5; first_got = 9; err_flag = 1 thereafter.
4. Inject 300 single-cycle errors with ERRW = 8 -> err_count saturates at 255; first_* still hold the first error; then pulse err_clr -> all four outputs read 0 next cycle.
5. Drop check_en for 3 cycles while cnt jumps arbitrarily, then raise it -> one SYNC cycle with no compare; no mismatch is reported for the jump.
6. Assert reset low asynchronously between edges during CHECK with err_flag = 1 -> all outputs 0 immediately; after release, IDLE until check_en is seen.

Source files
------------

// File: rtl/counter_monitor_if.sv
// Signals of the monitored up/down/load counter, as seen by the monitor.
// master drives the counter side; slave is the monitor's view.
interface counter_monitor_if #(
  parameter int WIDTH = 4
);
  logic             en_load;
  logic [WIDTH-1:0] load;
  logic             up_ndown;
  logic [WIDTH-1:0] cnt;

  modport master (output en_load, load, up_ndown, cnt);
  modport slave  (input  en_load, load, up_ndown, cnt);
endinterface

// File: rtl/counter_monitor.sv
// Predicts the monitored counter's next value each cycle and flags, counts
// and captures mismatches against the observed cnt.
//
//   state | meaning
//   IDLE  | monitor off, exp_cnt holds, nothing compared
//   SYNC  | one cycle: sample observed cnt/controls as baseline, no compare
//   CHECK | compare cnt against last prediction, re-predict from observed cnt
module counter_monitor #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 check_en,
  input  logic                 err_clr,
  counter_monitor_if.slave     mon,
  output logic                 mismatch,
  output logic                 err_flag,
  output logic [ERRW-1:0]      err_count,
  output logic [WIDTH-1:0]     exp_cnt,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_got
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  state_t           state, state_nxt;
  logic             upd_exp;
  logic             cmp;
  logic             miss;
  logic [WIDTH-1:0] pred;

  // load has priority over direction; wrap-around is natural modulo 2^WIDTH
  always_comb begin
    if (mon.en_load)       pred = mon.load;
    else if (mon.up_ndown) pred = mon.cnt + 1'b1;
    else                   pred = mon.cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    upd_exp   = 1'b0;
    cmp       = 1'b0;
    case (state)
      IDLE: begin
        if (check_en) state_nxt = SYNC;
      end
      SYNC: begin
        if (!check_en) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = CHECK;
          upd_exp   = 1'b1;
        end
      end
      CHECK: begin
        if (!check_en) begin
          state_nxt = IDLE;
        end else begin
          cmp     = 1'b1;
          upd_exp = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign miss = cmp && (mon.cnt != exp_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch  <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
      exp_cnt   <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      mismatch <= miss;
      // re-predicting from the observed value keeps one glitch to one error
      if (upd_exp) exp_cnt <= pred;
      if (err_clr) begin
        err_flag  <= 1'b0;
        err_count <= '0;
        first_exp <= '0;
        first_got <= '0;
      end else if (miss) begin
        err_flag <= 1'b1;
        if (err_count != {ERRW{1'b1}}) err_count <= err_count + 1'b1;
        if (!err_flag) begin
          first_exp <= exp_cnt;
          first_got <= mon.cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a vector table for the main run plus
// hand sequences for saturation, clear, check_en drop and async reset.
module tb_counter_monitor;
  localparam int WIDTH = 4;
  localparam int ERRW  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             check_en = 1'b0;
  logic             err_clr = 1'b0;
  logic             mismatch, err_flag;
  logic [ERRW-1:0]  err_count;
  logic [WIDTH-1:0] exp_cnt, first_exp, first_got;

  int tests_run = 0;
  int tests_failed = 0;

  counter_monitor_if #(.WIDTH(WIDTH)) bus ();

  counter_monitor #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk       (clk),
    .reset     (reset),
    .check_en  (check_en),
    .err_clr   (err_clr),
    .mon       (bus),
    .mismatch  (mismatch),
    .err_flag  (err_flag),
    .err_count (err_count),
    .exp_cnt   (exp_cnt),
    .first_exp (first_exp),
    .first_got (first_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ce, clr, el;
    logic [3:0] ld;
    logic       up;
    logic [3:0] cnt;
    logic       mm, flag;
    logic [7:0] ecount;
    logic [3:0] exp, fexp, fgot;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic ce, clr, el, input logic [3:0] ld,
                              input logic up, input logic [3:0] cnt,
                              input logic mm, flag, input logic [7:0] ecount,
                              input logic [3:0] exp, fexp, fgot);
    vec_t v;
    v.ce = ce; v.clr = clr; v.el = el; v.ld = ld; v.up = up; v.cnt = cnt;
    v.mm = mm; v.flag = flag; v.ecount = ecount;
    v.exp = exp; v.fexp = fexp; v.fgot = fgot;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic ce, clr, el, input logic [3:0] ld,
                       input logic up, input logic [3:0] c);
    check_en = ce; err_clr = clr;
    bus.en_load = el; bus.load = ld; bus.up_ndown = up; bus.cnt = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_all(input string tag, input logic mm, flag, input logic [7:0] ec,
                         input logic [3:0] ex, fe, fg);
    chk({tag, " mismatch"},  32'(mismatch),  32'(mm));
    chk({tag, " err_flag"},  32'(err_flag),  32'(flag));
    chk({tag, " err_count"}, 32'(err_count), 32'(ec));
    chk({tag, " exp_cnt"},   32'(exp_cnt),   32'(ex));
    chk({tag, " first_exp"}, 32'(first_exp), 32'(fe));
    chk({tag, " first_got"}, 32'(first_got), 32'(fg));
  endtask

  logic [3:0] exp_m, c;

  initial begin
    drive(0, 0, 0, 4'd0, 0, 4'd0);
    reset = 1'b0;
    tick();
    chk_all("reset", 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;

    // IDLE->SYNC, then SYNC samples a load of 0
    add(1, 0, 0, 4'd0, 1, 4'd7, 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    add(1, 0, 1, 4'd0, 1, 4'd7, 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    // correct up-count across the 15 -> 0 wrap
    for (int k = 0; k < 20; k++)
      add(1, 0, 0, 4'd0, 1, 4'(k), 0, 0, 8'd0, 4'(k + 1), 4'd0, 4'd0);
    // load 2 and count down through the 0 -> 15 wrap
    add(1, 0, 1, 4'd2, 0, 4'd4,  0, 0, 8'd0, 4'd2,  4'd0, 4'd0);
    add(1, 0, 0, 4'd0, 0, 4'd2,  0, 0, 8'd0, 4'd1,  4'd0, 4'd0);
    add(1, 0, 0, 4'd0, 0, 4'd1,  0, 0, 8'd0, 4'd0,  4'd0, 4'd0);
    add(1, 0, 0, 4'd0, 0, 4'd0,  0, 0, 8'd0, 4'd15, 4'd0, 4'd0);
    add(1, 0, 0, 4'd0, 0, 4'd15, 0, 0, 8'd0, 4'd14, 4'd0, 4'd0);
    add(1, 0, 0, 4'd0, 0, 4'd14, 0, 0, 8'd0, 4'd13, 4'd0, 4'd0);
    // load 5, then a glitch to 9 and the counter carries on from 9
    add(1, 0, 1, 4'd5, 0, 4'd13, 0, 0, 8'd0, 4'd5,  4'd0, 4'd0);
    add(1, 0, 0, 4'd0, 1, 4'd9,  1, 1, 8'd1, 4'd10, 4'd5, 4'd9);
    add(1, 0, 0, 4'd0, 1, 4'd10, 0, 1, 8'd1, 4'd11, 4'd5, 4'd9);
    add(1, 0, 0, 4'd0, 1, 4'd11, 0, 1, 8'd1, 4'd12, 4'd5, 4'd9);
    // load wins over up
    add(1, 0, 1, 4'd3, 1, 4'd12, 0, 1, 8'd1, 4'd3,  4'd5, 4'd9);

    foreach (vq[i]) begin
      drive(vq[i].ce, vq[i].clr, vq[i].el, vq[i].ld, vq[i].up, vq[i].cnt);
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].mm, vq[i].flag, vq[i].ecount,
              vq[i].exp, vq[i].fexp, vq[i].fgot);
    end

    // 300 consecutive errors: count saturates, first capture holds
    exp_m = 4'd3;
    for (int i = 0; i < 300; i++) begin
      c = exp_m + 4'd5;
      drive(1, 0, 0, 4'd0, 1, c);
      tick();
      exp_m = c + 4'd1;
      if (i == 99) chk("sat mid count", 32'(err_count), 32'd101);
    end
    chk_all("sat end", 1, 1, 8'd255, exp_m, 4'd5, 4'd9);

    // clear on the same edge as a mismatch: pulse still shows, clear wins
    c = exp_m + 4'd5;
    drive(1, 1, 0, 4'd0, 1, c);
    tick();
    exp_m = c + 4'd1;
    chk_all("clr+miss", 1, 0, 8'd0, exp_m, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, exp_m);
    tick();
    exp_m = exp_m + 4'd1;
    chk_all("after clr", 0, 0, 8'd0, exp_m, 4'd0, 4'd0);

    // drop check_en for three cycles with arbitrary jumps
    drive(0, 0, 0, 4'd0, 1, exp_m + 4'd3);
    tick();
    chk_all("drop1", 0, 0, 8'd0, exp_m, 4'd0, 4'd0);
    drive(0, 0, 0, 4'd0, 1, exp_m + 4'd7);
    tick();
    chk_all("drop2", 0, 0, 8'd0, exp_m, 4'd0, 4'd0);
    drive(0, 0, 1, 4'd6, 0, exp_m + 4'd9);
    tick();
    chk_all("drop3", 0, 0, 8'd0, exp_m, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd8);
    tick();
    chk_all("resync idle", 0, 0, 8'd0, exp_m, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd0);
    tick();
    chk_all("resync sync", 0, 0, 8'd0, 4'd1, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd1);
    tick();
    chk_all("resync check", 0, 0, 8'd0, 4'd2, 4'd0, 4'd0);

    // error, then async reset between edges
    drive(1, 0, 0, 4'd0, 1, 4'd7);
    tick();
    chk_all("pre-rst err", 1, 1, 8'd1, 4'd8, 4'd2, 4'd7);
    drive(1, 0, 0, 4'd0, 1, 4'd8);
    #3 reset = 1'b0;
    #1;
    chk_all("async rst", 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    #2 reset = 1'b1;
    drive(0, 0, 0, 4'd0, 1, 4'd5);
    tick();
    chk_all("post-rst idle1", 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    drive(0, 0, 0, 4'd0, 1, 4'd12);
    tick();
    chk_all("post-rst idle2", 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd3);
    tick();
    chk_all("post-rst sync entry", 0, 0, 8'd0, 4'd0, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd9);
    tick();
    chk_all("post-rst sync", 0, 0, 8'd0, 4'd10, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd10);
    tick();
    chk_all("post-rst check ok", 0, 0, 8'd0, 4'd11, 4'd0, 4'd0);
    drive(1, 0, 0, 4'd0, 1, 4'd0);
    tick();
    chk_all("post-rst check err", 1, 1, 8'd1, 4'd1, 4'd11, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
